ham_rx_corrector: RTL

HAM_RX_CORRECTOR -- requirements
Module: ham_rx_corrector

---
 rtl/ham_pkg.sv | 22 ++
 rtl/ham_rx_corrector_if.sv | 27 ++
 rtl/ham_syndrome.sv | 25 ++
 rtl/ham_rx_corrector.sv | 81 ++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) types and bit-position constants.
// Codeword layout: idx0=p1 idx1=p2 idx2=d0 idx3=p4 idx4=d1 idx5=d2 idx6=d3.
package ham_pkg;

  typedef logic [6:0] codeword_t;
  typedef logic [3:0] data_t;
  typedef logic [2:0] syndrome_t;

  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D0_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;

  // Codeword bits covered by each check bit.
  localparam codeword_t C1_MASK = 7'b1010101;
  localparam codeword_t C2_MASK = 7'b1100110;
  localparam codeword_t C3_MASK = 7'b1111000;

endpackage

// File: rtl/ham_rx_corrector_if.sv
// Codeword in / corrected beat out valid-ready bundle.
// master: upstream+downstream side; slave: the corrector.
interface ham_rx_corrector_if;
  import ham_pkg::*;

  logic      in_valid;
  logic      in_ready;
  codeword_t in_code;
  logic      out_valid;
  logic      out_ready;
  data_t     out_data;
  syndrome_t out_syndrome;
  logic      out_corrected;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_syndrome, out_corrected
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data,
    output out_syndrome, out_corrected
  );

endinterface

// File: rtl/ham_syndrome.sv
// Combinational Hamming(7,4) syndrome and single-bit correction.
// in: code; out: syn {c3,c2,c1}, data {d3,d2,d1,d0} after correction.
module ham_syndrome
  import ham_pkg::*;
(
  input  codeword_t code,
  output syndrome_t syn,
  output data_t     data
);

  codeword_t fixed;

  always_comb begin
    syn = {^(code & C3_MASK),
           ^(code & C2_MASK),
           ^(code & C1_MASK)};
    fixed = code;
    // Non-zero syndrome is the 1-based position of the bad bit.
    if (syn != 3'd0)
      fixed[syn - 3'd1] = ~code[syn - 3'd1];
    data = {fixed[D3_IDX], fixed[D2_IDX],
            fixed[D1_IDX], fixed[D0_IDX]};
  end

endmodule

// File: rtl/ham_rx_corrector.sv
// 2-stage Hamming(7,4) receive corrector with optional error counter.
// Ports: clk, rst_n, bus (slave), err_clr, err_count. Macro HAM_ERR_CNT_EN.
module ham_rx_corrector
  import ham_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ham_rx_corrector_if.slave    bus,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     err_count
);

  syndrome_t c_syn;
  data_t     c_data;

  ham_syndrome u_syn (
    .code (bus.in_code),
    .syn  (c_syn),
    .data (c_data)
  );

  logic      s1_valid;
  syndrome_t s1_syn;
  data_t     s1_data;
  logic      s2_ready;

  assign s2_ready     = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = !s1_valid | s2_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid          <= 1'b0;
      s1_syn            <= '0;
      s1_data           <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_data      <= '0;
      bus.out_syndrome  <= '0;
      bus.out_corrected <= 1'b0;
    end else begin
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_syn  <= c_syn;
          s1_data <= c_data;
        end
      end
      if (s2_ready) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_data      <= s1_data;
          bus.out_syndrome  <= s1_syn;
          bus.out_corrected <= |s1_syn;
        end
      end
    end
  end

`ifdef HAM_ERR_CNT_EN
  logic fire;

  assign fire = bus.out_valid & bus.out_ready
              & bus.out_corrected;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (err_clr)
      err_count <= '0;
    else if (fire && !(&err_count))
      err_count <= err_count + 1'b1;
  end
`else
  logic unused_clr;

  assign unused_clr = err_clr;
  assign err_count  = '0;
`endif

endmodule
